// File: rtl/line_ring_buf_pkg.sv
// Shared defaults for the N-line ring buffer and the RAM-depth helper.
package line_buf_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_PIX_W    = 10;
  localparam int unsigned DEF_LINE_PIX = 640;
  localparam int unsigned DEF_LINE_W   = 2;

  function automatic int unsigned ram_depth(input int unsigned line_w,
                                            input int unsigned pix_w);
    return (32'd1 << line_w) * (32'd1 << pix_w);
  endfunction

endpackage

// File: rtl/line_ring_buf_if.sv
// Writer/reader bus of the line ring buffer; master drives requests, slave is the buffer.
interface line_ring_buf_if
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned LINE_W = DEF_LINE_W
);

  logic              Flush;
  logic              WrValid;
  logic [DATA_W-1:0] WrData;
  logic              WrReady;
  logic              WrLineEnd;
  logic              RdEn;
  logic [PIX_W-1:0]  RdPix;
  logic              RdLineDone;
  logic [DATA_W-1:0] RdData;
  logic              RdDataValid;
  logic              LineAvail;
  logic [LINE_W:0]   FillLevel;
  logic              Overrun;
  logic              Underrun;

  modport master (
    output Flush, WrValid, WrData, RdEn, RdPix, RdLineDone,
    input  WrReady, WrLineEnd, RdData, RdDataValid, LineAvail, FillLevel,
           Overrun, Underrun
  );

  modport slave (
    input  Flush, WrValid, WrData, RdEn, RdPix, RdLineDone,
    output WrReady, WrLineEnd, RdData, RdDataValid, LineAvail, FillLevel,
           Overrun, Underrun
  );

endinterface

// File: rtl/line_ring_ram.sv
// Simple dual-port line storage: one write port, one registered read port.
module line_ring_ram
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LINE_W = DEF_LINE_W,
  parameter int unsigned PIX_W  = DEF_PIX_W
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    we_i,
  input  logic [LINE_W+PIX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    re_i,
  input  logic [LINE_W+PIX_W-1:0] raddr_i,
  output logic [DATA_W-1:0]       rdata_o
);

  localparam int unsigned DEPTH = ram_depth(LINE_W, PIX_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset; it holds whenever no read is enabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_ring_buf.sv
// N-line ring buffer: write/read line pointers, complete-line fill count, sticky
// error flags and the two-stage read pipeline around line_ring_ram.
module line_ring_buf
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned PIX_W    = DEF_PIX_W,
  parameter int unsigned LINE_PIX = DEF_LINE_PIX,
  parameter int unsigned LINE_W   = DEF_LINE_W
) (
  input logic           CLK,
  input logic           RST_N,
  line_ring_buf_if.slave bus
);

  localparam int unsigned       NUM_LINES = 2 ** LINE_W;
  localparam logic [LINE_W:0]   FULL_LVL  = (LINE_W+1)'(NUM_LINES);
  localparam logic [LINE_W:0]   FILL_ONE  = (LINE_W+1)'(1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(LINE_PIX - 1);
  localparam logic [PIX_W-1:0]  PIX_ONE   = PIX_W'(1);
  localparam logic [LINE_W-1:0] PTR_ONE   = LINE_W'(1);

  logic [LINE_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LINE_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PIX_W-1:0]        wr_pix_q, wr_pix_d;
  logic [LINE_W:0]         fill_q, fill_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    line_avail_q, line_avail_d;
  logic                    wr_line_end_q, wr_line_end_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;
  logic [LINE_W+PIX_W-1:0] rd_addr_q, rd_addr_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    rd_valid_q, rd_valid_d;

  logic              wr_acc;
  logic              line_done;
  logic              line_release;
  logic              rd_issue;
  logic [DATA_W-1:0] rd_data;

  assign wr_acc       = bus.WrValid & wr_ready_q & ~bus.Flush;
  assign line_done    = wr_acc & (wr_pix_q == LAST_PIX);
  assign line_release = bus.RdLineDone & line_avail_q & ~bus.Flush;
  assign rd_issue     = bus.RdEn & line_avail_q & ~bus.Flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_pix_d      = wr_pix_q;
    fill_d        = fill_q;
    overrun_d     = overrun_q;
    underrun_d    = underrun_q;
    wr_line_end_d = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_pend_d     = 1'b0;
    rd_valid_d    = 1'b0;

    if (bus.Flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      wr_pix_d   = '0;
      fill_d     = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      overrun_d  = overrun_q | (bus.WrValid & ~wr_ready_q);
      underrun_d = underrun_q | ((bus.RdEn | bus.RdLineDone) & ~line_avail_q);
      rd_valid_d = rd_pend_q;
      rd_pend_d  = rd_issue;
      if (rd_issue) begin
        rd_addr_d = {rd_ptr_q, bus.RdPix};
      end

      if (wr_acc) begin
        if (line_done) begin
          wr_pix_d      = '0;
          wr_ptr_d      = wr_ptr_q + PTR_ONE;
          wr_line_end_d = 1'b1;
        end else begin
          wr_pix_d = wr_pix_q + PIX_ONE;
        end
      end

      if (line_release) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      // A completion and a release in the same cycle cancel out.
      unique case ({line_done, line_release})
        2'b10:   fill_d = fill_q + FILL_ONE;
        2'b01:   fill_d = fill_q - FILL_ONE;
        default: fill_d = fill_q;
      endcase
    end

    wr_ready_d   = (fill_d != FULL_LVL);
    line_avail_d = (fill_d != '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_pix_q      <= '0;
      fill_q        <= '0;
      wr_ready_q    <= 1'b1;
      line_avail_q  <= 1'b0;
      wr_line_end_q <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_pix_q      <= wr_pix_d;
      fill_q        <= fill_d;
      wr_ready_q    <= wr_ready_d;
      line_avail_q  <= line_avail_d;
      wr_line_end_q <= wr_line_end_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
      rd_addr_q     <= rd_addr_d;
      rd_pend_q     <= rd_pend_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // Gating the RAM read on Flush keeps RdData at its pre-flush value.
  line_ring_ram #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .PIX_W  (PIX_W)
  ) u_ram (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .we_i    (wr_acc),
    .waddr_i ({wr_ptr_q, wr_pix_q}),
    .wdata_i (bus.WrData),
    .re_i    (rd_pend_q & ~bus.Flush),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_data)
  );

  assign bus.RdData      = rd_data;
  assign bus.RdDataValid = rd_valid_q;
  assign bus.WrReady     = wr_ready_q;
  assign bus.WrLineEnd   = wr_line_end_q;
  assign bus.LineAvail   = line_avail_q;
  assign bus.FillLevel   = fill_q;
  assign bus.Overrun     = overrun_q;
  assign bus.Underrun    = underrun_q;

endmodule

// File: tb/tb_line_ring_buf.sv
// Bench for line_ring_buf: reset/underrun table, directed line sequences and a
// randomized run, all checked against a queue-based model of buffered lines.
module tb_line_ring_buf;

  localparam int LP = 640;
  localparam int NL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_ring_buf_if #(.DATA_W(16), .PIX_W(10), .LINE_W(2)) bus ();

  line_ring_buf #(
    .DATA_W   (16),
    .PIX_W    (10),
    .LINE_PIX (640),
    .LINE_W   (2)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: pixels of complete lines (oldest first) and of the line being filled.
  logic [15:0] done_q[$];
  logic [15:0] part_q[$];
  logic        m_wle = 1'b0, m_ovr = 1'b0, m_und = 1'b0;
  logic        s1_v = 1'b0, s1_k = 1'b0, m_rdv = 1'b0, m_rdk = 1'b0;
  logic [15:0] s1_d = '0, m_rd = '0;

  typedef struct {
    logic        fl, wv, re, rld;
    logic [9:0]  rp;
    logic        ready, avail, ovr, und, rdv;
    int          fill;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_fill();
    return done_q.size() / LP;
  endfunction

  task automatic model_step(input logic fl, input logic wv, input logic [15:0] wd,
                            input logic re, input int rp, input logic rld);
    logic ready, avail;
    if (fl) begin
      done_q.delete();
      part_q.delete();
      m_wle = 1'b0; m_ovr = 1'b0; m_und = 1'b0; s1_v = 1'b0; m_rdv = 1'b0;
      return;
    end
    ready = (m_fill() != NL);
    avail = (m_fill() != 0);
    m_ovr = m_ovr | (wv & ~ready);
    m_und = m_und | ((re | rld) & ~avail);
    m_rdv = s1_v;
    if (s1_v) begin
      m_rd  = s1_d;
      m_rdk = s1_k;
    end
    s1_v = re & avail;
    if (s1_v) begin
      s1_k = (rp < LP);
      s1_d = s1_k ? done_q[rp] : 16'h0;
    end
    if (rld && avail) repeat (LP) void'(done_q.pop_front());
    m_wle = 1'b0;
    if (wv && ready) begin
      part_q.push_back(wd);
      if (part_q.size() == LP) begin
        while (part_q.size() > 0) done_q.push_back(part_q.pop_front());
        m_wle = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic fl, input logic wv, input logic [15:0] wd,
                     input logic re, input int rp, input logic rld);
    bus.Flush      = fl;
    bus.WrValid    = wv;
    bus.WrData     = wd;
    bus.RdEn       = re;
    bus.RdPix      = 10'(rp);
    bus.RdLineDone = rld;
    @(posedge clk);
    model_step(fl, wv, wd, re, rp, rld);
    #1;
  endtask

  task automatic check_model();
    chk("WrReady",     32'(bus.WrReady),     32'(m_fill() != NL));
    chk("LineAvail",   32'(bus.LineAvail),   32'(m_fill() != 0));
    chk("FillLevel",   32'(bus.FillLevel),   32'(m_fill()));
    chk("WrLineEnd",   32'(bus.WrLineEnd),   32'(m_wle));
    chk("Overrun",     32'(bus.Overrun),     32'(m_ovr));
    chk("Underrun",    32'(bus.Underrun),    32'(m_und));
    chk("RdDataValid", 32'(bus.RdDataValid), 32'(m_rdv));
    if (m_rdv && m_rdk) chk("RdData", 32'(bus.RdData), 32'(m_rd));
  endtask

  task automatic wr_line(input logic [15:0] base);
    for (int i = 0; i < LP; i++) begin
      cyc(1'b0, 1'b1, base | 16'(i), 1'b0, 0, 1'b0);
      check_model();
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b0);
    check_model();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wle_cnt;

    bus.Flush = 1'b0; bus.WrValid = 1'b0; bus.WrData = '0;
    bus.RdEn = 1'b0; bus.RdPix = '0; bus.RdLineDone = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_WrReady",     32'(bus.WrReady),     32'd1);
    chk("rst_LineAvail",   32'(bus.LineAvail),   32'd0);
    chk("rst_FillLevel",   32'(bus.FillLevel),   32'd0);
    chk("rst_WrLineEnd",   32'(bus.WrLineEnd),   32'd0);
    chk("rst_RdDataValid", 32'(bus.RdDataValid), 32'd0);
    chk("rst_RdData",      32'(bus.RdData),      32'd0);
    chk("rst_Overrun",     32'(bus.Overrun),     32'd0);
    chk("rst_Underrun",    32'(bus.Underrun),    32'd0);
    rst_n = 1'b1;

    // fl wv re rld rp | ready avail ovr und rdv fill
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    for (int v = 0; v < 9; v++) begin
      cyc(vecs[v].fl, vecs[v].wv, 16'hABCD, vecs[v].re, int'(vecs[v].rp), vecs[v].rld);
      chk($sformatf("vec%0d_WrReady", v),     32'(bus.WrReady),     32'(vecs[v].ready));
      chk($sformatf("vec%0d_LineAvail", v),   32'(bus.LineAvail),   32'(vecs[v].avail));
      chk($sformatf("vec%0d_Overrun", v),     32'(bus.Overrun),     32'(vecs[v].ovr));
      chk($sformatf("vec%0d_Underrun", v),    32'(bus.Underrun),    32'(vecs[v].und));
      chk($sformatf("vec%0d_RdDataValid", v), 32'(bus.RdDataValid), 32'(vecs[v].rdv));
      chk($sformatf("vec%0d_FillLevel", v),   32'(bus.FillLevel),   32'(vecs[v].fill));
    end

    // Bring-up: one line of pixel indices, then read pixel 5.
    wle_cnt = 0;
    for (int i = 0; i < LP; i++) begin
      cyc(1'b0, 1'b1, 16'(i), 1'b0, 0, 1'b0);
      check_model();
      wle_cnt += int'(bus.WrLineEnd);
    end
    idle();
    wle_cnt += int'(bus.WrLineEnd);
    chk("bringup_wle_count", 32'(wle_cnt), 32'd1);
    chk("bringup_fill", 32'(bus.FillLevel), 32'd1);
    chk("bringup_avail", 32'(bus.LineAvail), 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 5, 1'b0);
    chk("bringup_rdv_early", 32'(bus.RdDataValid), 32'd0);
    idle();
    chk("bringup_rdv", 32'(bus.RdDataValid), 32'd1);
    chk("bringup_rdata", 32'(bus.RdData), 32'd5);

    // Fill to full, overrun, then release one line.
    for (int k = 1; k < NL; k++) wr_line(16'(k << 12));
    chk("full_fill", 32'(bus.FillLevel), 32'd4);
    chk("full_ready", 32'(bus.WrReady), 32'd0);
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, 0, 1'b0);
    check_model();
    chk("full_overrun", 32'(bus.Overrun), 32'd1);
    for (int p = 0; p < LP; p++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1, p, 1'b0);
      check_model();
    end
    idle(); idle();
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 0, 1'b0);
    idle();
    chk("full_line0_pix0", 32'(bus.RdData), 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b1);
    check_model();
    chk("release_fill", 32'(bus.FillLevel), 32'd3);
    chk("release_ready", 32'(bus.WrReady), 32'd1);

    // Line completion coinciding with a release.
    for (int i = 0; i < LP - 1; i++) begin
      cyc(1'b0, 1'b1, 16'h4000 | 16'(i), 1'b0, 0, 1'b0);
      check_model();
    end
    cyc(1'b0, 1'b1, 16'h4000 | 16'(LP - 1), 1'b0, 0, 1'b1);
    check_model();
    chk("simul_fill", 32'(bus.FillLevel), 32'd3);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 7, 1'b0);
    idle();
    chk("simul_rdptr", 32'(bus.RdData), 32'h2007);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b1);
    check_model();
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b1);
    check_model();
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 639, 1'b0);
    idle();
    chk("simul_wrptr", 32'(bus.RdData), 32'h427F);

    // Ring wrap-around: ten lines, each read in full then released.
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 0, 1'b0);
    check_model();
    for (int k = 0; k < 10; k++) begin
      wr_line(16'(k << 8));
      for (int p = 0; p < LP; p++) begin
        cyc(1'b0, 1'b0, 16'h0, 1'b1, p, 1'b0);
        check_model();
      end
      idle(); idle();
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b1);
      check_model();
    end
    chk("wrap_fill", 32'(bus.FillLevel), 32'd0);

    // Flush mid-line with a read in flight.
    wr_line(16'h1000);
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b1, 16'h3000 | 16'(i), 1'b0, 0, 1'b0);
      check_model();
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 3, 1'b0);
    check_model();
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 0, 1'b0);
    chk("flush_fill", 32'(bus.FillLevel), 32'd0);
    chk("flush_ready", 32'(bus.WrReady), 32'd1);
    chk("flush_avail", 32'(bus.LineAvail), 32'd0);
    chk("flush_ovr", 32'(bus.Overrun), 32'd0);
    chk("flush_und", 32'(bus.Underrun), 32'd0);
    chk("flush_wle", 32'(bus.WrLineEnd), 32'd0);
    chk("flush_rdv0", 32'(bus.RdDataValid), 32'd0);
    idle();
    chk("flush_rdv1", 32'(bus.RdDataValid), 32'd0);
    idle();
    chk("flush_rdv2", 32'(bus.RdDataValid), 32'd0);
    wr_line(16'h5000);
    chk("flush_newline_fill", 32'(bus.FillLevel), 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 0, 1'b0);
    idle();
    chk("flush_newline_pix0", 32'(bus.RdData), 32'h5000);

    // Randomized traffic against the model.
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 0, 1'b0);
    check_model();
    for (int n = 0; n < 6000; n++) begin
      logic fl, wv, re, rld;
      int   rp;
      fl  = ($urandom_range(0, 599) == 0);
      wv  = ($urandom_range(0, 7) != 0);
      re  = $urandom_range(0, 1) == 1;
      rld = ($urandom_range(0, 1199) == 0);
      rp  = ($urandom_range(0, 15) == 0) ? 1023 : int'($urandom_range(0, LP - 1));
      cyc(fl, wv, 16'($urandom), re, rp, rld);
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_ring_buf.md
Name: line_ring_buf

Overview:
- Parametrised N-line ring buffer between the AXI-side pixel writer and the display-side raster reader; successor to the fixed two-line ping-pong line buffer.
- Writer streams pixels with a valid/ready handshake. The block generates write addresses and advances lines itself.
- Reader addresses pixels within the oldest complete line and releases it when done.
- Occupancy tracking gives back-pressure, plus sticky overrun/underrun flags.

Parameters:
- DATA_W, 16, pixel width (RGB565 default).
- PIX_W, 10, pixel-address width; must satisfy LINE_PIX <= 2**PIX_W.
- LINE_PIX, 640, pixels per line.
- LINE_W, 2, line-index width; NUM_LINES = 2**LINE_W (min LINE_W=1).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- Flush  in  1  synchronous clear of pointers, fill level and flags
- WrValid  in  1  write pixel valid
- WrData  in  DATA_W  write pixel
- WrReady  out  1  buffer can accept a pixel
- WrLineEnd  out  1  one-cycle pulse when the last pixel of a line is accepted
- RdEn  in  1  read request for pixel RdPix of the current read line
- RdPix  in  PIX_W  pixel index within the read line
- RdLineDone  in  1  release the current read line
- RdData  out  DATA_W  read pixel
- RdDataValid  out  1  RdData valid
- LineAvail  out  1  at least one complete line is buffered
- FillLevel  out  LINE_W+1  number of complete lines held, 0..NUM_LINES
- Overrun  out  1  sticky: WrValid while WrReady=0
- Underrun  out  1  sticky: RdEn or RdLineDone while LineAvail=0

Behaviour:
- Reset (RST_N low, async) and Flush (sync, priority over all other inputs) both clear:
  - WrPtr, RdPtr, WrPix and FillLevel to 0;
  - WrReady to 1, and LineAvail, WrLineEnd, RdDataValid, Overrun and Underrun to 0;
  - RdData to 0 on reset only; on Flush RdData holds its value.
- Write acceptance:
  - A pixel is accepted when WrValid & WrReady.
  - It is stored at {WrPtr, WrPix}, then WrPix increments.
  - At WrPix == LINE_PIX-1: WrPix wraps to 0, WrPtr increments modulo NUM_LINES, and WrLineEnd pulses in the following cycle.
- WrReady = (FillLevel != NUM_LINES), registered. The line being filled is never a counted line, so the writer cannot overwrite an unreleased line.
- Read path:
  - When RdEn & LineAvail, the address {RdPtr, RdPix} is registered, then the RAM read is registered.
  - RdData and RdDataValid appear exactly 2 cycles after RdEn.
  - RdEn while LineAvail=0 issues no read and sets Underrun.
  - RdPix >= LINE_PIX returns undefined data but RdDataValid still pulses; it is not flagged.
- RdLineDone while LineAvail=1: RdPtr increments modulo NUM_LINES. RdLineDone while LineAvail=0 is ignored and sets Underrun.
- FillLevel update per cycle:
  - +1 on line completion;
  - -1 on a valid release;
  - unchanged when both occur in the same cycle.
- LineAvail = (FillLevel != 0).
- Full: when the last pixel of a line completes and FillLevel becomes NUM_LINES, WrReady drops in the next cycle. A pixel presented in that cycle is not accepted (WrReady=0) and sets Overrun.
- RAM port conflicts: simultaneous write and read of the same RAM address cannot occur, because the write line is never the read line while LineAvail=1.
- Reads in flight at Flush: any read issued in the 2 cycles before Flush is discarded. RdDataValid is forced to 0 for 2 cycles after Flush.

Decomposition:
- Shared package (line_buf_pkg): the default DATA_W, PIX_W, LINE_PIX and LINE_W values, and the function deriving the RAM depth NUM_LINES*2**PIX_W.
- One sub-module, line_ring_ram:
  - simple dual-port RAM, depth 2**(LINE_W+PIX_W), width DATA_W;
  - one write port, one registered read port;
  - no reset on storage;
  - replaces per-line RAM instances.
- Top level contains only pointers, fill counter, flags and read-pipeline registers.

Test Plan:
- Bring-up: after reset, write 640 pixels with WrData=pixel index. Require:
  - WrLineEnd pulses once, FillLevel=1, LineAvail=1;
  - RdEn with RdPix=5 gives RdData=5 two cycles later, with RdDataValid.
- Fill to full with LINE_W=2: write 4 lines. Require:
  - FillLevel=4 and WrReady=0;
  - one extra WrValid sets Overrun=1 and memory is unchanged;
  - RdLineDone gives FillLevel=3 and WrReady=1 the next cycle.
- Simultaneous events: complete a line in the same cycle as RdLineDone. Require FillLevel unchanged, RdPtr and WrPtr both advanced.
- Ring wrap-around: stream 10 lines with line k data = k<<8 | pix, reading and releasing each line as it completes. Require every read to match and pointers to wrap 3→0 with no corruption.
- Underrun: RdEn and RdLineDone with FillLevel=0. Require Underrun=1, RdDataValid never pulses, FillLevel stays 0.
- Flush mid-line: write 300 pixels, issue an RdEn, then assert Flush. Require:
  - all counters 0, flags cleared, WrReady=1;
  - no RdDataValid for the 2 cycles after Flush;
  - the next 640 writes form line 0.
